// File: rtl/serial_adder_ctrl_if.sv
// Operand-request and result-return handshakes of the bit-serial adder.
// The master side issues operands and takes results; the slave side is the adder.
// Status only; adds no cycles and no storage.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    modport master (
        output start_valid, op_a, op_b, c_in, res_ready,
        input  start_ready, res_valid, sum, c_out, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, c_in, res_ready,
        output start_ready, res_valid, sum, c_out, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// One-bit full adder used as the datapath of the serial sequencer.
// Combinational; zero latency.
// No handshake; the sequencer only uses it in the ADD state.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, carry kept in a flop.
// Latency: WIDTH ADD cycles after the accept edge, then one DONE cycle minimum.
// Backpressure: result holds in DONE until res_ready; start_ready is low outside IDLE.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave io
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_nxt;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign sum_nxt = WIDTH'({fa_s, sum_sh} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            a_sh           <= '0;
            b_sh           <= '0;
            sum_sh         <= '0;
            carry          <= 1'b0;
            cnt            <= '0;
            io.sum         <= '0;
            io.c_out       <= 1'b0;
            io.start_ready <= 1'b1;
            io.res_valid   <= 1'b0;
            io.busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start_valid) begin
                        a_sh           <= io.op_a;
                        b_sh           <= io.op_b;
                        carry          <= io.c_in;
                        cnt            <= '0;
                        state          <= ADD;
                        io.start_ready <= 1'b0;
                        io.busy        <= 1'b1;
                    end
                end
                ADD: begin
                    sum_sh <= sum_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state        <= DONE;
                        io.sum       <= sum_nxt;
                        io.c_out     <= fa_co;
                        io.res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (io.res_ready) begin
                        state          <= IDLE;
                        io.res_valid   <= 1'b0;
                        io.busy        <= 1'b0;
                        io.start_ready <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    io.res_valid   <= 1'b0;
                    io.busy        <= 1'b0;
                    io.start_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 1-bit instance checked against
// the plain arithmetic sum a + b + c_in.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) io8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) io1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(io8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(io1));

    // Present one request for a single edge; the target instance is expected idle.
    task automatic accept(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        if (w1) begin
            io1.op_a = a[0]; io1.op_b = b[0]; io1.c_in = ci; io1.start_valid = 1'b1;
        end else begin
            io8.op_a = a; io8.op_b = b; io8.c_in = ci; io8.start_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        io1.start_valid = 1'b0;
        io8.start_valid = 1'b0;
    endtask

    // k = index of the first edge after the accept edge that samples res_valid high, -1 on timeout.
    task automatic wait_res(input bit w1, output int k);
        k = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (w1 ? io1.res_valid : io8.res_valid) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic consume(input bit w1);
        if (w1) io1.res_ready = 1'b1; else io8.res_ready = 1'b1;
        @(posedge clk);
        #1;
        io1.res_ready = 1'b0;
        io8.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (io8.start_ready !== 1'b1) begin fails++; $display("FAIL reset_start_ready got %b want 1", io8.start_ready); end
        tests++; if (io8.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", io8.res_valid); end
        tests++; if (io8.sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", io8.sum); end
        tests++; if (io8.c_out !== 1'b0) begin fails++; $display("FAIL reset_c_out got %b want 0", io8.c_out); end
        tests++; if (io8.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", io8.busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_latency();
        int k;
        accept(1'b0, 8'h00, 8'h00, 1'b0);
        wait_res(1'b0, k);
        tests++; if (k != 9) begin fails++; $display("FAIL zero_latency got %0d want 9", k); end
        tests++; if ({io8.c_out, io8.sum} !== 9'h000) begin fails++; $display("FAIL zero_result got %h want 000", {io8.c_out, io8.sum}); end
        tests++; if (io8.busy !== 1'b1 || io8.start_ready !== 1'b0) begin
            fails++; $display("FAIL done_flags got busy=%b rdy=%b want busy=1 rdy=0", io8.busy, io8.start_ready);
        end
        consume(1'b0);
    endtask

    task automatic test_corners();
        logic [7:0] av [2] = '{8'hFF, 8'hA5};
        logic [7:0] bv [2] = '{8'h01, 8'h5A};
        logic       cv [2] = '{1'b0, 1'b1};
        int k;
        for (int i = 0; i < 2; i++) begin
            accept(1'b0, av[i], bv[i], cv[i]);
            wait_res(1'b0, k);
            tests++; if (k != 9) begin fails++; $display("FAIL corner_latency[%0d] got %0d want 9", i, k); end
            tests++; if ({io8.c_out, io8.sum} !== 9'h100) begin
                fails++; $display("FAIL corner_result[%0d] got %h want 100", i, {io8.c_out, io8.sum});
            end
            consume(1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp_r;
        int k;
        exp_r = 9'h12 + 9'h34;
        accept(1'b0, 8'h12, 8'h34, 1'b0);
        wait_res(1'b0, k);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (io8.res_valid !== 1'b1 || {io8.c_out, io8.sum} !== exp_r || io8.start_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure[%0d] got vld=%b res=%h rdy=%b want vld=1 res=%h rdy=0",
                         c, io8.res_valid, {io8.c_out, io8.sum}, io8.start_ready, exp_r);
            end
            io8.start_valid = (c == 2);
            io8.op_a = 8'h77; io8.op_b = 8'h66; io8.c_in = 1'b1;
            @(negedge clk);
        end
        io8.start_valid = 1'b0;
        consume(1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++; if (io8.busy !== 1'b0 || io8.start_ready !== 1'b1) begin
                fails++; $display("FAIL ignored_start[%0d] got busy=%b rdy=%b want busy=0 rdy=1", c, io8.busy, io8.start_ready);
            end
        end
        tests++; if ({io8.c_out, io8.sum} !== exp_r) begin
            fails++; $display("FAIL result_hold got %h want %h", {io8.c_out, io8.sum}, exp_r);
        end
    endtask

    task automatic test_reset_midop();
        int k;
        accept(1'b0, 8'hC3, 8'h81, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (io8.res_valid !== 1'b0 || io8.sum !== 8'h00 || io8.c_out !== 1'b0 || io8.start_ready !== 1'b1 || io8.busy !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset got vld=%b sum=%h co=%b rdy=%b busy=%b want 0 00 0 1 0",
                     io8.res_valid, io8.sum, io8.c_out, io8.start_ready, io8.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        accept(1'b0, 8'h3C, 8'h0F, 1'b0);
        wait_res(1'b0, k);
        tests++; if (k != 9 || {io8.c_out, io8.sum} !== 9'h04B) begin
            fails++; $display("FAIL after_reset got k=%0d res=%h want k=9 res=04b", k, {io8.c_out, io8.sum});
        end
        consume(1'b0);
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] exp_r;
        int k;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            exp_r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            accept(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0]);
            wait_res(1'b1, k);
            tests++;
            if (k != 2 || {io1.c_out, io1.sum} !== exp_r) begin
                fails++; $display("FAIL width1[%0d] got k=%0d res=%b want k=2 res=%b", i, k, {io1.c_out, io1.sum}, exp_r);
            end
            consume(1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expq [$];
        logic [8:0] e;
        int nacc = 0;
        int last = 0;
        int cyc = 0;
        io8.res_ready = 1'b1;
        io8.start_valid = 1'b1;
        while ((nacc < 256 || expq.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (nacc == 256) io8.start_valid = 1'b0;
            if (io8.res_valid === 1'b1) begin
                e = (expq.size() != 0) ? expq.pop_front() : 9'h1FF;
                tests++;
                if ({io8.c_out, io8.sum} !== e) begin
                    fails++; $display("FAIL b2b_result got %h want %h", {io8.c_out, io8.sum}, e);
                end
            end
            io8.op_a = 8'($urandom);
            io8.op_b = 8'($urandom);
            io8.c_in = 1'($urandom);
            if (nacc < 256 && io8.start_ready === 1'b1) begin
                expq.push_back(9'(io8.op_a) + 9'(io8.op_b) + 9'(io8.c_in));
                if (nacc > 0) begin
                    tests++;
                    if (cyc - last != 10) begin
                        fails++; $display("FAIL b2b_spacing got %0d want 10", cyc - last);
                    end
                end
                last = cyc;
                nacc++;
            end
        end
        tests++; if (nacc != 256 || expq.size() != 0) begin
            fails++; $display("FAIL b2b_timeout got accepts=%0d pending=%0d want 256 0", nacc, expq.size());
        end
        io8.start_valid = 1'b0;
        io8.res_ready = 1'b0;
    endtask

    initial begin
        io8.start_valid = 1'b0; io8.op_a = '0; io8.op_b = '0; io8.c_in = 1'b0; io8.res_ready = 1'b0;
        io1.start_valid = 1'b0; io1.op_a = '0; io1.op_b = '0; io1.c_in = 1'b0; io1.res_ready = 1'b0;
        test_reset();
        test_zero_latency();
        test_corners();
        test_backpressure();
        test_reset_midop();
        test_width1();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
